// File: rtl/cam_lru_pkg.sv
// Shared types for the cam_lru tag store.
//   cam_op_t    : request opcode carried on req_op
//   cam_state_t : control FSM states (idle / flush sweep)
package cam_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_FILL   = 2'd1,
        OP_INVAL  = 2'd2,
        OP_FLUSH  = 2'd3
    } cam_op_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } cam_state_t;

endpackage

// File: rtl/cam_lru_age.sv
// LRU age tracker for cam_lru. Each entry carries an age; the ages always form
// a permutation of 0..WORDS-1, 0 = most recently used, WORDS-1 = oldest.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (ages reset to age[i]=i)
//   touch_en    : mark touch_idx as most recently used this cycle
//   touch_idx   : entry being touched
//   victim_idx  : entry holding the maximum age (replacement candidate)
module cam_lru_age #(
    parameter int WORDS = 8,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             touch_en,
    input  logic [IDX_W-1:0] touch_idx,
    output logic [IDX_W-1:0] victim_idx
);

    logic [IDX_W-1:0] age [WORDS];

    // Touch: everything younger than the touched entry ages by one, the touched
    // entry becomes youngest. Older entries keep their age, so the set stays a
    // permutation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                age[i] <= IDX_W'(i);
            end
        end else if (touch_en) begin
            for (int i = 0; i < WORDS; i++) begin
                if (IDX_W'(i) == touch_idx) begin
                    age[i] <= '0;
                end else if (age[i] < age[touch_idx]) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        victim_idx = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (age[i] == IDX_W'(WORDS - 1)) begin
                victim_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cam_lru.sv
// Fully-associative tag/data store with LRU replacement.
// One request per cycle on a valid/ready port; lookup/fill/inval respond with a
// registered one-cycle strobe the cycle after acceptance. Flush sweeps the valid
// bits one entry per cycle and responds when the sweep completes.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready low during flush and reset)
//   req_op              : cam_op_t opcode
//   req_tag, req_data   : tag to match/write, fill data
//   rsp_valid           : one-cycle response strobe
//   rsp_hit             : tag was present
//   rsp_data            : matched data on lookup hit, else 0
//   rsp_index           : entry matched or written
//   rsp_evict           : fill replaced a valid entry holding another tag
//   occupancy           : number of valid entries
module cam_lru import cam_pkg::*; #(
    parameter  int WORDS  = 8,
    parameter  int BITS   = 8,
    parameter  int TAG_SZ = 8,
    localparam int IDX_W  = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [TAG_SZ-1:0] req_tag,
    input  logic [BITS-1:0]   req_data,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [BITS-1:0]   rsp_data,
    output logic [IDX_W-1:0]  rsp_index,
    output logic              rsp_evict,
    output logic [IDX_W:0]    occupancy
);

    logic [BITS-1:0]   data_mem [WORDS];
    logic [TAG_SZ-1:0] tag_mem  [WORDS];
    logic [WORDS-1:0]  val_mem;
    logic [WORDS-1:0]  val_nxt;

    cam_state_t        state;
    cam_state_t        state_nxt;
    logic [IDX_W-1:0]  flush_cnt;
    logic              flush_done;

    cam_op_t           op;
    logic              accept;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              has_free;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  victim_idx;
    logic [IDX_W-1:0]  fill_idx;
    logic              wr_en;
    logic              touch_en;
    logic [IDX_W-1:0]  touch_idx;

    function automatic logic [IDX_W:0] popcount(input logic [WORDS-1:0] v);
        logic [IDX_W:0] n;
        n = '0;
        for (int i = 0; i < WORDS; i++) begin
            n = n + (IDX_W+1)'(v[i]);
        end
        return n;
    endfunction

    assign op     = cam_op_t'(req_op);
    assign accept = req_valid && req_ready;

    // Descending scans so the lowest matching / free index is the one kept.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        has_free = 1'b0;
        free_idx = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (val_mem[i] && (tag_mem[i] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!val_mem[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    cam_lru_age #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_age (
        .clk        (clk),
        .rst        (rst),
        .touch_en   (touch_en),
        .touch_idx  (touch_idx),
        .victim_idx (victim_idx)
    );

    // Fill target: existing tag in place, else first empty slot, else LRU victim.
    assign fill_idx = hit      ? hit_idx  :
                      has_free ? free_idx : victim_idx;

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        flush_done = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = !rst;
                if (accept && (op == OP_FLUSH)) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_cnt == IDX_W'(WORDS - 1)) begin
                    flush_done = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        val_nxt   = val_mem;
        wr_en     = 1'b0;
        touch_en  = 1'b0;
        touch_idx = '0;
        if (state == S_FLUSH) begin
            val_nxt[flush_cnt] = 1'b0;
        end else if (accept) begin
            case (op)
                OP_LOOKUP: begin
                    touch_en  = hit;
                    touch_idx = hit_idx;
                end
                OP_FILL: begin
                    wr_en             = 1'b1;
                    val_nxt[fill_idx] = 1'b1;
                    touch_en          = 1'b1;
                    touch_idx         = fill_idx;
                end
                OP_INVAL: begin
                    if (hit) begin
                        val_nxt[hit_idx] = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            flush_cnt <= '0;
            val_mem   <= '0;
            occupancy <= '0;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_data  <= '0;
            rsp_index <= '0;
            rsp_evict <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                data_mem[i] <= '0;
                tag_mem[i]  <= '0;
            end
        end else begin
            state     <= state_nxt;
            val_mem   <= val_nxt;
            occupancy <= popcount(val_nxt);
            rsp_valid <= 1'b0;
            // Counter wraps to 0 on the last sweep step, ready for the next flush.
            flush_cnt <= (state == S_FLUSH) ? flush_cnt + 1'b1 : '0;

            if (wr_en) begin
                tag_mem[fill_idx]  <= req_tag;
                data_mem[fill_idx] <= req_data;
            end

            if (flush_done) begin
                rsp_valid <= 1'b1;
                rsp_hit   <= 1'b0;
                rsp_data  <= '0;
                rsp_index <= '0;
                rsp_evict <= 1'b0;
            end else if (accept && (op != OP_FLUSH)) begin
                rsp_valid <= 1'b1;
                rsp_hit   <= hit;
                rsp_data  <= '0;
                rsp_index <= hit ? hit_idx : '0;
                rsp_evict <= 1'b0;
                case (op)
                    OP_LOOKUP: rsp_data <= hit ? data_mem[hit_idx] : '0;
                    OP_FILL: begin
                        rsp_index <= fill_idx;
                        rsp_evict <= !hit && !has_free;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cam_lru.sv
module tb_cam_lru;
    import cam_pkg::*;

    localparam int W  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [7:0]    req_tag;
    logic [7:0]    req_data;
    logic          rsp_valid;
    logic          rsp_hit;
    logic [7:0]    rsp_data;
    logic [IW-1:0] rsp_index;
    logic          rsp_evict;
    logic [IW:0]   occupancy;

    always #5 clk = ~clk;

    cam_lru #(.WORDS(W), .BITS(8), .TAG_SZ(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_hit   (rsp_hit),
        .rsp_data  (rsp_data),
        .rsp_index (rsp_index),
        .rsp_evict (rsp_evict),
        .occupancy (occupancy)
    );

    typedef struct packed {
        logic          hit;
        logic [7:0]    data;
        logic [IW-1:0] index;
        logic          evict;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic       m_val  [W];
    logic [7:0] m_tag  [W];
    logic [7:0] m_data [W];
    int         m_age  [W];

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            m_val[i]  = 1'b0;
            m_tag[i]  = 8'h00;
            m_data[i] = 8'h00;
            m_age[i]  = i;
        end
    endtask

    task automatic model_touch(input int idx);
        int a;
        a = m_age[idx];
        for (int j = 0; j < W; j++) begin
            if (m_age[j] < a) m_age[j] = m_age[j] + 1;
        end
        m_age[idx] = 0;
    endtask

    function automatic int model_occ();
        int n;
        n = 0;
        for (int i = 0; i < W; i++) n += int'(m_val[i]);
        return n;
    endfunction

    task automatic model_req(input logic [1:0] op, input logic [7:0] tag, input logic [7:0] data);
        exp_t e;
        int   hi;
        int   idx;
        e  = '0;
        hi = -1;
        for (int i = W - 1; i >= 0; i--) begin
            if (m_val[i] && m_tag[i] == tag) hi = i;
        end
        case (cam_op_t'(op))
            OP_LOOKUP: begin
                if (hi >= 0) begin
                    e.hit   = 1'b1;
                    e.data  = m_data[hi];
                    e.index = IW'(hi);
                    model_touch(hi);
                end
                exp_q.push_back(e);
            end
            OP_FILL: begin
                idx = -1;
                if (hi >= 0) begin
                    idx   = hi;
                    e.hit = 1'b1;
                end else begin
                    for (int i = W - 1; i >= 0; i--) if (!m_val[i]) idx = i;
                    if (idx < 0) begin
                        for (int i = 0; i < W; i++) if (m_age[i] == W - 1) idx = i;
                        e.evict = 1'b1;
                    end
                end
                m_val[idx]  = 1'b1;
                m_tag[idx]  = tag;
                m_data[idx] = data;
                model_touch(idx);
                e.index = IW'(idx);
                exp_q.push_back(e);
            end
            OP_INVAL: begin
                if (hi >= 0) begin
                    e.hit     = 1'b1;
                    e.index   = IW'(hi);
                    m_val[hi] = 1'b0;
                end
                exp_q.push_back(e);
            end
            default: begin
                for (int i = 0; i < W; i++) m_val[i] = 1'b0;
                exp_q.push_back(e);
            end
        endcase
    endtask

    // Advance one clock; any response strobe is popped off the scoreboard and compared.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rsp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected_rsp: got hit=%0b data=%h idx=%0d evict=%0b with nothing expected",
                         rsp_hit, rsp_data, rsp_index, rsp_evict);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_hit, rsp_data, rsp_index, rsp_evict} !== e) begin
                    errors++;
                    $display("FAIL scoreboard_rsp: got hit=%0b data=%h idx=%0d evict=%0b, want hit=%0b data=%h idx=%0d evict=%0b",
                             rsp_hit, rsp_data, rsp_index, rsp_evict, e.hit, e.data, e.index, e.evict);
                end
            end
        end
    endtask

    task automatic issue(input logic v, input logic [1:0] op, input logic [7:0] tag, input logic [7:0] data);
        req_valid = v;
        req_op    = op;
        req_tag   = tag;
        req_data  = data;
        if (v && req_ready === 1'b1) model_req(op, tag, data);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_tag   = 8'h00;
        req_data  = 8'h00;
        model_reset();
        repeat (3) tick();
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%0b rsp_valid=%0b occ=%0d, want 0 0 0", req_ready, rsp_valid, occupancy);
        end
        checks++;
        if (rsp_hit !== 1'b0 || rsp_data !== 8'h00 || rsp_index !== 2'd0 || rsp_evict !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: got hit=%0b data=%h idx=%0d evict=%0b, want all 0", rsp_hit, rsp_data, rsp_index, rsp_evict);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after: got %0b want 1", req_ready);
        end
    endtask

    task automatic test_lookup_empty();
        issue(1'b1, OP_LOOKUP, 8'h11, 8'h00);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_data !== 8'h00 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL lookup_empty: got valid=%0b hit=%0b data=%h occ=%0d, want 1 0 00 0", rsp_valid, rsp_hit, rsp_data, occupancy);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, OP_FILL, 8'hA0 + 8'(i), 8'h10 + 8'(i));
            checks++;
            if (rsp_valid !== 1'b1 || rsp_index !== IW'(i) || rsp_evict !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d: got valid=%0b idx=%0d evict=%0b, want 1 %0d 0", i, rsp_valid, rsp_index, rsp_evict, i);
            end
        end
        checks++;
        if (occupancy !== 3'd4) begin
            errors++;
            $display("FAIL fill_occupancy: got %0d want 4", occupancy);
        end
        issue(1'b1, OP_LOOKUP, 8'hA2, 8'h00);
        checks++;
        if (rsp_hit !== 1'b1 || rsp_data !== 8'h12 || rsp_index !== 2'd2) begin
            errors++;
            $display("FAIL lookup_A2: got hit=%0b data=%h idx=%0d, want 1 12 2", rsp_hit, rsp_data, rsp_index);
        end
    endtask

    task automatic test_lru_evict();
        issue(1'b1, OP_LOOKUP, 8'hA0, 8'h00);
        issue(1'b1, OP_FILL, 8'hB0, 8'h55);
        checks++;
        if (rsp_index !== 2'd1 || rsp_evict !== 1'b1 || rsp_hit !== 1'b0) begin
            errors++;
            $display("FAIL lru_victim: got idx=%0d evict=%0b hit=%0b, want 1 1 0", rsp_index, rsp_evict, rsp_hit);
        end
        issue(1'b1, OP_LOOKUP, 8'hA1, 8'h00);
        checks++;
        if (rsp_hit !== 1'b0 || rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL lookup_evicted: got hit=%0b data=%h, want 0 00", rsp_hit, rsp_data);
        end
    endtask

    task automatic test_fill_hit_inval();
        issue(1'b1, OP_FILL, 8'hA3, 8'h77);
        checks++;
        if (rsp_hit !== 1'b1 || rsp_index !== 2'd3 || rsp_evict !== 1'b0 || occupancy !== 3'd4) begin
            errors++;
            $display("FAIL fill_in_place: got hit=%0b idx=%0d evict=%0b occ=%0d, want 1 3 0 4", rsp_hit, rsp_index, rsp_evict, occupancy);
        end
        issue(1'b1, OP_INVAL, 8'hA3, 8'h00);
        checks++;
        if (rsp_hit !== 1'b1 || rsp_index !== 2'd3 || occupancy !== 3'd3) begin
            errors++;
            $display("FAIL inval_hit: got hit=%0b idx=%0d occ=%0d, want 1 3 3", rsp_hit, rsp_index, occupancy);
        end
        issue(1'b1, OP_FILL, 8'hC0, 8'h66);
        checks++;
        if (rsp_index !== 2'd3 || rsp_evict !== 1'b0 || occupancy !== 3'd4) begin
            errors++;
            $display("FAIL fill_into_hole: got idx=%0d evict=%0b occ=%0d, want 3 0 4", rsp_index, rsp_evict, occupancy);
        end
    endtask

    task automatic test_flush();
        issue(1'b1, OP_FLUSH, 8'h00, 8'h00);
        for (int k = 0; k < W; k++) begin
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_busy_%0d: got ready=%0b rsp_valid=%0b, want 0 0", k, req_ready, rsp_valid);
            end
            tick();
        end
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b1 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL flush_done: got rsp_valid=%0b ready=%0b occ=%0d, want 1 1 0", rsp_valid, req_ready, occupancy);
        end
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, OP_LOOKUP, (i == 0) ? 8'hA0 : (i == 1) ? 8'hB0 : (i == 2) ? 8'hC0 : 8'hA2, 8'h00);
            checks++;
            if (rsp_hit !== 1'b0) begin
                errors++;
                $display("FAIL flush_lookup_%0d: got hit=%0b want 0", i, rsp_hit);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        issue(1'b1, OP_FILL, 8'h31, 8'h01);
        issue(1'b1, OP_FILL, 8'h32, 8'h02);
        issue(1'b1, OP_LOOKUP, 8'h31, 8'h00);
        issue(1'b1, OP_FLUSH, 8'h00, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
        model_reset();
        tick();
        rst = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || occupancy !== 3'd0) begin
                errors++;
                $display("FAIL abort_flush_%0d: got rsp_valid=%0b occ=%0d, want 0 0", k, rsp_valid, occupancy);
            end
        end
        for (int i = 0; i < 4; i++) issue(1'b1, OP_FILL, 8'hD0 + 8'(i), 8'h40 + 8'(i));
        issue(1'b1, OP_FILL, 8'hE0, 8'h99);
        checks++;
        if (rsp_index !== 2'd0 || rsp_evict !== 1'b1 || occupancy !== 3'd4) begin
            errors++;
            $display("FAIL post_reset_evict: got idx=%0d evict=%0b occ=%0d, want 0 1 4", rsp_index, rsp_evict, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        int         r;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 19);
            op = (r < 8) ? OP_LOOKUP : (r < 15) ? OP_FILL : (r < 19) ? OP_INVAL : OP_FLUSH;
            issue($urandom_range(0, 4) != 0, op, 8'hA0 + 8'($urandom_range(0, 5)), 8'($urandom));
        end
        repeat (W + 2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_pending: got %0d responses outstanding, want 0", exp_q.size());
        end
        checks++;
        if (int'(occupancy) != model_occ()) begin
            errors++;
            $display("FAIL b2b_occupancy: got %0d want %0d", occupancy, model_occ());
        end
    endtask

    initial begin
        test_reset();
        test_lookup_empty();
        test_fill();
        test_lru_evict();
        test_fill_hit_inval();
        test_flush();
        test_reset_mid_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
